// File: rtl/dbuf_pingpong_ctrl.sv
// Ping-pong double-buffer controller: fills one bank while the other drains through a 2-entry skid buffer.
// Optional drained-frame counter enabled by defining DBUF_CTRL_FRAME_CNT_EN.
module dbuf_pingpong_ctrl #(
   parameter int AWIDTH    = 11,
   parameter int NUM_WORDS = 2048,
   parameter int DWIDTH    = 40
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   input  logic [DWIDTH-1:0] in_data,
   output logic              in_ready,
   output logic              out_valid,
   output logic [DWIDTH-1:0] out_data,
   input  logic              out_ready,
   output logic [1:0]        mem_wr_en,
   output logic [AWIDTH-1:0] mem_wr_addr,
   output logic [DWIDTH-1:0] mem_wr_data,
   output logic              mem_rd_bank,
   output logic [AWIDTH-1:0] mem_rd_addr,
   input  logic [DWIDTH-1:0] mem_rd_data0,
   input  logic [DWIDTH-1:0] mem_rd_data1,
   output logic [15:0]       frame_cnt
);

   localparam logic [AWIDTH-1:0] LAST_ADDR = AWIDTH'(NUM_WORDS - 1);

   logic              wr_bank, rd_bank;
   logic [1:0]        bank_full;
   logic [AWIDTH-1:0] wr_ptr, rd_ptr;

   logic              wr_fire, wr_last, rd_last;
   logic [1:0]        set_mask, clr_mask;
   logic              vld_p0;
   logic              vld_p1, bank_p1;
   logic [DWIDTH-1:0] rd_data_p1;

   logic [1:0]        skid_cnt, occ;
   logic [DWIDTH-1:0] skid_q0, skid_q1;
   logic              pop;

   // ---- write side ----
   assign in_ready    = !bank_full[wr_bank];
   assign wr_fire     = in_valid && in_ready && !reset;
   assign wr_last     = (wr_ptr == LAST_ADDR);
   assign mem_wr_en   = wr_fire ? (wr_bank ? 2'b10 : 2'b01) : 2'b00;
   assign mem_wr_addr = wr_ptr;
   assign mem_wr_data = in_data;
   assign set_mask    = (wr_fire && wr_last) ? (wr_bank ? 2'b10 : 2'b01) : 2'b00;

   // ---- read issue (p0) ----
   // A word popped this cycle frees its slot, so the issue credit counts it as
   // already gone; this is what sustains one read per cycle.
   assign pop         = out_valid && out_ready;
   assign occ         = skid_cnt + 2'(vld_p1) - 2'(pop);
   assign vld_p0      = bank_full[rd_bank] && (occ < 2'd2);
   assign rd_last     = (rd_ptr == LAST_ADDR);
   assign clr_mask    = (vld_p0 && rd_last) ? (rd_bank ? 2'b10 : 2'b01) : 2'b00;
   assign mem_rd_bank = rd_bank;
   assign mem_rd_addr = rd_ptr;

   // ---- read return (p1) ----
   assign rd_data_p1  = bank_p1 ? mem_rd_data1 : mem_rd_data0;

   assign out_valid   = (skid_cnt != 2'd0);
   assign out_data    = out_valid ? skid_q0 : '0;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_bank   <= 1'b0;
         rd_bank   <= 1'b0;
         bank_full <= 2'b00;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         vld_p1    <= 1'b0;
         bank_p1   <= 1'b0;
         skid_cnt  <= 2'd0;
      end else begin
         if (wr_fire) begin
            wr_ptr <= wr_last ? '0 : wr_ptr + AWIDTH'(1);
            if (wr_last) wr_bank <= ~wr_bank;
         end
         if (vld_p0) begin
            rd_ptr <= rd_last ? '0 : rd_ptr + AWIDTH'(1);
            if (rd_last) rd_bank <= ~rd_bank;
         end
         bank_full <= (bank_full & ~clr_mask) | set_mask;
         vld_p1    <= vld_p0;
         bank_p1   <= rd_bank;
         skid_cnt  <= occ;
      end
   end

   // Skid storage carries data only; its validity lives in skid_cnt.
   always_ff @(posedge clk) begin
      case ({vld_p1, pop})
         2'b10: begin
            if (skid_cnt == 2'd0) skid_q0 <= rd_data_p1;
            else                  skid_q1 <= rd_data_p1;
         end
         2'b01: skid_q0 <= skid_q1;
         2'b11: begin
            if (skid_cnt == 2'd1) begin
               skid_q0 <= rd_data_p1;
            end else begin
               skid_q0 <= skid_q1;
               skid_q1 <= rd_data_p1;
            end
         end
         default: ;
      endcase
   end

`ifdef DBUF_CTRL_FRAME_CNT_EN
   logic [15:0] frame_cnt_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)                 frame_cnt_q <= 16'd0;
      else if (vld_p0 && rd_last) frame_cnt_q <= frame_cnt_q + 16'd1;
   end

   assign frame_cnt = frame_cnt_q;
`else
   assign frame_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_dbuf_pingpong_ctrl.sv
// Scoreboard bench for dbuf_pingpong_ctrl with a 4-word-per-bank memory model.
module tb_dbuf_pingpong_ctrl;
   localparam int AW = 2;
   localparam int NW = 4;
   localparam int DW = 40;
`ifdef DBUF_CTRL_FRAME_CNT_EN
   localparam bit FC_EN = 1'b1;
`else
   localparam bit FC_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          in_valid = 1'b0;
   logic [DW-1:0] in_data = '0;
   logic          in_ready;
   logic          out_valid;
   logic [DW-1:0] out_data;
   logic          out_ready = 1'b0;
   logic [1:0]    mem_wr_en;
   logic [AW-1:0] mem_wr_addr;
   logic [DW-1:0] mem_wr_data;
   logic          mem_rd_bank;
   logic [AW-1:0] mem_rd_addr;
   logic [DW-1:0] mem_rd_data0, mem_rd_data1;
   logic [15:0]   frame_cnt;

   logic [DW-1:0] m0 [NW];
   logic [DW-1:0] m1 [NW];

   int            tests = 0;
   int            fails = 0;
   int            n_out = 0;
   int            wr_idx = 0;
   int            cyc = 0;
   logic [DW-1:0] sb [$];

   dbuf_pingpong_ctrl #(.AWIDTH(AW), .NUM_WORDS(NW), .DWIDTH(DW)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
      .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
      .mem_rd_bank(mem_rd_bank), .mem_rd_addr(mem_rd_addr),
      .mem_rd_data0(mem_rd_data0), .mem_rd_data1(mem_rd_data1),
      .frame_cnt(frame_cnt)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Synchronous-read bank model: data appears one cycle after the address
   always @(posedge clk) begin
      if (mem_wr_en[0]) m0[mem_wr_addr] <= mem_wr_data;
      if (mem_wr_en[1]) m1[mem_wr_addr] <= mem_wr_data;
      mem_rd_data0 <= m0[mem_rd_addr];
      mem_rd_data1 <= m1[mem_rd_addr];
   end

   function automatic logic [15:0] exp_fc(input int n);
      return FC_EN ? 16'(n) : 16'd0;
   endfunction

   // Scoreboard: writes pushed at handshake, outputs popped and compared
   task automatic monitor();
      logic [1:0]    exp_en;
      logic [DW-1:0] exp_d;
      forever begin
         @(negedge clk);
         if (reset) begin
            sb.delete();
            wr_idx = 0;
         end else begin
            tests++;
            if (in_valid && in_ready) begin
               exp_en = ((wr_idx / NW) % 2 == 0) ? 2'b01 : 2'b10;
               if (mem_wr_en !== exp_en || mem_wr_addr !== AW'(wr_idx % NW) || mem_wr_data !== in_data) begin
                  fails++;
                  $display("FAIL wr_port idx=%0d: en=%b addr=%0d data=%h, required en=%b addr=%0d data=%h",
                           wr_idx, mem_wr_en, mem_wr_addr, mem_wr_data, exp_en, wr_idx % NW, in_data);
               end
               sb.push_back(in_data);
               wr_idx++;
            end else if (mem_wr_en !== 2'b00) begin
               fails++;
               $display("FAIL wr_idle: mem_wr_en=%b, required 00", mem_wr_en);
            end
            if (out_valid && out_ready) begin
               tests++;
               if (sb.size() == 0) begin
                  fails++;
                  $display("FAIL out_unexpected: out_data=%h, required no output", out_data);
               end else begin
                  exp_d = sb.pop_front();
                  if (out_data !== exp_d) begin
                     fails++;
                     $display("FAIL out_data #%0d: got %h, required %h", n_out, out_data, exp_d);
                  end
               end
               n_out++;
            end
         end
      end
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      reset = 1'b1;
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      n_out = 0;
   endtask

   task automatic write_word(input logic [DW-1:0] d);
      int n = 0;
      in_valid = 1'b1;
      in_data  = d;
      @(negedge clk);
      while (!in_ready && n < 100) begin
         n++;
         @(negedge clk);
      end
      if (!in_ready) begin
         tests++;
         fails++;
         $display("FAIL write_timeout: in_ready=%b, required 1 within 100 cycles", in_ready);
      end
      @(posedge clk); #1;
   endtask

   task automatic wait_outputs(input int n, input int budget, output int c);
      c = 0;
      while (n_out < n && c < budget) begin
         @(posedge clk);
         c++;
      end
      tests++;
      if (n_out < n) begin
         fails++;
         $display("FAIL drain_timeout: n_out=%0d, required %0d", n_out, n);
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      tests++; if (mem_wr_en !== 2'b00) begin fails++; $display("FAIL rst_wr_en: got %b, required 00", mem_wr_en); end
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_out_valid: got %b, required 0", out_valid); end
      tests++; if (out_data !== '0) begin fails++; $display("FAIL rst_out_data: got %h, required 0", out_data); end
      tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rst_in_ready: got %b, required 1", in_ready); end
      tests++; if (mem_rd_bank !== 1'b0) begin fails++; $display("FAIL rst_rd_bank: got %b, required 0", mem_rd_bank); end
      tests++; if (mem_rd_addr !== '0) begin fails++; $display("FAIL rst_rd_addr: got %0d, required 0", mem_rd_addr); end
      tests++; if (frame_cnt !== 16'd0) begin fails++; $display("FAIL rst_frame_cnt: got %0d, required 0", frame_cnt); end
      @(posedge clk); #1;
      reset = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) write_word(40'h50 + 40'(i));
      // asynchronous assertion mid-cycle with a pending write and a loaded skid
      #2 reset = 1'b1;
      #1;
      tests++; if (mem_wr_en !== 2'b00) begin fails++; $display("FAIL arst_wr_en: got %b, required 00", mem_wr_en); end
      tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL arst_in_ready: got %b, required 1", in_ready); end
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL arst_out_valid: got %b, required 0", out_valid); end
      tests++; if (out_data !== '0) begin fails++; $display("FAIL arst_out_data: got %h, required 0", out_data); end
      tests++; if (mem_rd_addr !== '0) begin fails++; $display("FAIL arst_rd_addr: got %0d, required 0", mem_rd_addr); end
      repeat (2) @(posedge clk);
      #1;
      in_valid = 1'b0;
      reset = 1'b0;
      n_out = 0;
   endtask

   task automatic test_single_frame();
      int c;
      do_reset();
      out_ready = 1'b1;
      for (int i = 1; i <= 4; i++) write_word(40'(i));
      in_valid = 1'b0;
      c = 0;
      do begin
         @(negedge clk);
         c++;
      end while (!out_valid && c < 20);
      tests++;
      if (c != 3) begin fails++; $display("FAIL first_latency: got %0d cycles, required 3", c); end
      wait_outputs(4, 50, c);
      repeat (5) @(posedge clk);
      #1;
      tests++; if (n_out != 4) begin fails++; $display("FAIL single_count: got %0d, required 4", n_out); end
      tests++; if (sb.size() != 0) begin fails++; $display("FAIL single_left: got %0d, required 0", sb.size()); end
      tests++; if (frame_cnt !== exp_fc(1)) begin fails++; $display("FAIL single_frame_cnt: got %0d, required %0d", frame_cnt, exp_fc(1)); end
   endtask

   task automatic test_back_to_back();
      int start, c;
      do_reset();
      out_ready = 1'b1;
      start = cyc;
      for (int i = 0; i < 12; i++) write_word(40'h1000 + 40'(i * 7));
      in_valid = 1'b0;
      tests++;
      if (cyc - start != 12) begin fails++; $display("FAIL b2b_write_cycles: got %0d, required 12", cyc - start); end
      wait_outputs(12, 100, c);
      tests++;
      if (c > 7) begin fails++; $display("FAIL b2b_drain_cycles: got %0d, required at most 7", c); end
      repeat (5) @(posedge clk);
      #1;
      tests++; if (n_out != 12) begin fails++; $display("FAIL b2b_count: got %0d, required 12", n_out); end
      tests++; if (sb.size() != 0) begin fails++; $display("FAIL b2b_left: got %0d, required 0", sb.size()); end
      tests++; if (frame_cnt !== exp_fc(3)) begin fails++; $display("FAIL b2b_frame_cnt: got %0d, required %0d", frame_cnt, exp_fc(3)); end
   endtask

   task automatic test_backpressure();
      int c;
      do_reset();
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) write_word(40'h100 + 40'(i));
      in_valid = 1'b0;
      @(negedge clk);
      tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_bank1_ready: got %b, required 1", in_ready); end
      @(posedge clk); #1;
      for (int i = 4; i < 8; i++) write_word(40'h100 + 40'(i));
      in_valid = 1'b0;
      @(negedge clk);
      tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_full_ready: got %b, required 0", in_ready); end
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_data  = 40'h999;
      repeat (5) @(posedge clk);
      #1;
      tests++; if (sb.size() != 8) begin fails++; $display("FAIL bp_held: accepted %0d, required 8", sb.size()); end
      tests++; if (n_out != 0) begin fails++; $display("FAIL bp_no_out: got %0d outputs, required 0", n_out); end
      out_ready = 1'b1;
      write_word(40'h999);
      in_valid = 1'b0;
      wait_outputs(8, 100, c);
      repeat (5) @(posedge clk);
      #1;
      tests++; if (n_out != 8) begin fails++; $display("FAIL bp_count: got %0d, required 8", n_out); end
      tests++; if (sb.size() != 1) begin fails++; $display("FAIL bp_pending: got %0d, required 1", sb.size()); end
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL bp_idle_valid: got %b, required 0", out_valid); end
   endtask

   task automatic test_toggle();
      int c = 0;
      int max_occ = 0;
      do_reset();
      out_ready = 1'b0;
      for (int i = 0; i < 8; i++) write_word(40'h200 + 40'(i * 3));
      in_valid = 1'b0;
      while (n_out < 8 && c < 200) begin
         @(posedge clk); #1;
         out_ready = ~out_ready;
         if (int'(dut.skid_cnt) > max_occ) max_occ = int'(dut.skid_cnt);
         c++;
      end
      out_ready = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      tests++; if (n_out != 8) begin fails++; $display("FAIL tog_count: got %0d, required 8", n_out); end
      tests++; if (sb.size() != 0) begin fails++; $display("FAIL tog_left: got %0d, required 0", sb.size()); end
      tests++; if (max_occ > 2) begin fails++; $display("FAIL tog_occupancy: got %0d, required at most 2", max_occ); end
      tests++; if (frame_cnt !== exp_fc(2)) begin fails++; $display("FAIL tog_frame_cnt: got %0d, required %0d", frame_cnt, exp_fc(2)); end
   endtask

   task automatic test_reset_midframe();
      int c;
      do_reset();
      out_ready = 1'b0;
      for (int i = 0; i < 6; i++) write_word(40'h300 + 40'(i));
      in_valid = 1'b0;
      do_reset();
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) write_word(40'hA + 40'(i));
      in_valid = 1'b0;
      wait_outputs(4, 50, c);
      repeat (5) @(posedge clk);
      #1;
      tests++; if (n_out != 4) begin fails++; $display("FAIL mid_count: got %0d, required 4", n_out); end
      tests++; if (sb.size() != 0) begin fails++; $display("FAIL mid_left: got %0d, required 0", sb.size()); end
      tests++; if (frame_cnt !== exp_fc(1)) begin fails++; $display("FAIL mid_frame_cnt: got %0d, required %0d", frame_cnt, exp_fc(1)); end
   endtask

   initial begin
      reset = 1'b1;
      in_valid = 1'b1;
      in_data = 40'hDEAD;
      out_ready = 1'b1;
      fork
         monitor();
      join_none
      test_reset();
      test_single_frame();
      test_back_to_back();
      test_backpressure();
      test_toggle();
      test_reset_midframe();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "time limit");
   end

endmodule
